// File: rtl/wt_mem_req_arbiter_if.sv
// Cache-side request/return and memory-side port bundle for wt_mem_req_arbiter.
// "slave" is the arbiter view, "master" is the view of whatever drives it.
interface wt_mem_req_arbiter_if #(
    parameter int PayloadWidth = 128,
    parameter int RtrnWidth    = 128,
    parameter int TidWidth     = 2
);
    logic                    icache_data_req_i;
    logic                    icache_data_ack_o;
    logic [PayloadWidth-1:0] icache_data_i;
    logic [TidWidth-1:0]     icache_tid_i;
    logic                    dcache_data_req_i;
    logic                    dcache_data_ack_o;
    logic [PayloadWidth-1:0] dcache_data_i;
    logic [TidWidth-1:0]     dcache_tid_i;
    logic                    mem_req_valid_o;
    logic                    mem_req_ready_i;
    logic [PayloadWidth-1:0] mem_req_o;
    logic [TidWidth-1:0]     mem_req_tid_o;
    logic                    mem_req_src_o;
    logic                    mem_rtrn_vld_i;
    logic [TidWidth-1:0]     mem_rtrn_tid_i;
    logic [RtrnWidth-1:0]    mem_rtrn_i;
    logic                    icache_rtrn_vld_o;
    logic                    dcache_rtrn_vld_o;
    logic [RtrnWidth-1:0]    rtrn_data_o;
    logic                    busy_o;
    logic                    err_o;

    modport slave (
        input  icache_data_req_i, icache_data_i, icache_tid_i,
        input  dcache_data_req_i, dcache_data_i, dcache_tid_i,
        input  mem_req_ready_i, mem_rtrn_vld_i, mem_rtrn_tid_i, mem_rtrn_i,
        output icache_data_ack_o, dcache_data_ack_o,
        output mem_req_valid_o, mem_req_o, mem_req_tid_o, mem_req_src_o,
        output icache_rtrn_vld_o, dcache_rtrn_vld_o, rtrn_data_o, busy_o, err_o
    );

    modport master (
        output icache_data_req_i, icache_data_i, icache_tid_i,
        output dcache_data_req_i, dcache_data_i, dcache_tid_i,
        output mem_req_ready_i, mem_rtrn_vld_i, mem_rtrn_tid_i, mem_rtrn_i,
        input  icache_data_ack_o, dcache_data_ack_o,
        input  mem_req_valid_o, mem_req_o, mem_req_tid_o, mem_req_src_o,
        input  icache_rtrn_vld_o, dcache_rtrn_vld_o, rtrn_data_o, busy_o, err_o
    );
endinterface

// File: rtl/wt_mem_req_arbiter.sv
// Round-robin arbiter of I$ (src 0) and D$ (src 1) requests onto one memory port.
// A per-TID table remembers which cache issued each in-flight transaction so
// returns can be steered back; per-source counters cap outstanding traffic.
module wt_mem_req_arbiter #(
    parameter int PayloadWidth   = 128,
    parameter int RtrnWidth      = 128,
    parameter int TidWidth       = 2,
    parameter int MaxOutstanding = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    wt_mem_req_arbiter_if.slave   bus
);
    localparam int Depth = 2 ** TidWidth;
    localparam int CntW  = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    logic                    out_vld_q,  out_vld_d;
    logic [PayloadWidth-1:0] out_data_q, out_data_d;
    logic [TidWidth-1:0]     out_tid_q,  out_tid_d;
    logic                    out_src_q,  out_src_d;
    logic [Depth-1:0]        tbl_vld_q,  tbl_vld_d;
    logic [Depth-1:0]        tbl_src_q,  tbl_src_d;
    logic [1:0][CntW-1:0]    cnt_q,      cnt_d;
    logic                    rr_q,       rr_d;

    logic                    rtrn_hit_s;
    logic                    rtrn_src_s;
    logic [1:0]              elig_s;
    logic                    gnt_vld_s;
    logic                    gnt_src_s;
    logic                    load_ok_s;
    logic                    ack_i_s, ack_d_s;
    logic                    rtrn_i_s, rtrn_d_s, err_s;
    logic [RtrnWidth-1:0]    rtrn_data_s;

    // Return routing first (it frees table/counter space), then grant and output-stage update.
    always_comb begin
        out_vld_d   = out_vld_q;
        out_data_d  = out_data_q;
        out_tid_d   = out_tid_q;
        out_src_d   = out_src_q;
        tbl_vld_d   = tbl_vld_q;
        tbl_src_d   = tbl_src_q;
        cnt_d       = cnt_q;
        rr_d        = rr_q;
        ack_i_s     = 1'b0;
        ack_d_s     = 1'b0;
        rtrn_i_s    = 1'b0;
        rtrn_d_s    = 1'b0;
        err_s       = 1'b0;
        rtrn_data_s = '0;
        gnt_vld_s   = 1'b0;
        gnt_src_s   = 1'b0;

        // Gating with rst_ni keeps the combinational outputs quiet while reset is held.
        rtrn_hit_s = rst_ni & bus.mem_rtrn_vld_i & tbl_vld_q[bus.mem_rtrn_tid_i];
        rtrn_src_s = tbl_src_q[bus.mem_rtrn_tid_i];
        if (rtrn_hit_s) begin
            tbl_vld_d[bus.mem_rtrn_tid_i] = 1'b0;
            cnt_d[rtrn_src_s]             = cnt_d[rtrn_src_s] - CntOne;
            rtrn_i_s                      = ~rtrn_src_s;
            rtrn_d_s                      = rtrn_src_s;
            rtrn_data_s                   = bus.mem_rtrn_i;
        end else if (rst_ni && bus.mem_rtrn_vld_i) begin
            err_s = 1'b1;
        end else begin
            err_s = 1'b0;
        end

        if (out_vld_q && bus.mem_req_ready_i) begin
            out_vld_d = 1'b0;
        end else begin
            out_vld_d = out_vld_q;
        end
        load_ok_s = ~out_vld_q | bus.mem_req_ready_i;

        // Eligibility uses post-return state so a freed slot/ID is reusable this cycle.
        elig_s[0] = rst_ni & bus.icache_data_req_i & (cnt_d[0] < CntMax)
                    & ~tbl_vld_d[bus.icache_tid_i];
        elig_s[1] = rst_ni & bus.dcache_data_req_i & (cnt_d[1] < CntMax)
                    & ~tbl_vld_d[bus.dcache_tid_i];

        case (elig_s)
            2'b11:   begin gnt_vld_s = load_ok_s; gnt_src_s = rr_q; end
            2'b01:   begin gnt_vld_s = load_ok_s; gnt_src_s = 1'b0; end
            2'b10:   begin gnt_vld_s = load_ok_s; gnt_src_s = 1'b1; end
            default: begin gnt_vld_s = 1'b0;      gnt_src_s = 1'b0; end
        endcase

        if (gnt_vld_s) begin
            ack_i_s    = ~gnt_src_s;
            ack_d_s    = gnt_src_s;
            out_vld_d  = 1'b1;
            out_src_d  = gnt_src_s;
            out_data_d = gnt_src_s ? bus.dcache_data_i : bus.icache_data_i;
            out_tid_d  = gnt_src_s ? bus.dcache_tid_i  : bus.icache_tid_i;
            tbl_vld_d[out_tid_d] = 1'b1;
            tbl_src_d[out_tid_d] = gnt_src_s;
            cnt_d[gnt_src_s]     = cnt_d[gnt_src_s] + CntOne;
            rr_d                 = ~gnt_src_s;
        end else begin
            rr_d = rr_q;
        end
    end

    // State registers: output stage, ID table, per-source counters, RR pointer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_tid_q  <= '0;
            out_src_q  <= 1'b0;
            tbl_vld_q  <= '0;
            tbl_src_q  <= '0;
            cnt_q      <= '0;
            rr_q       <= 1'b0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_tid_q  <= out_tid_d;
            out_src_q  <= out_src_d;
            tbl_vld_q  <= tbl_vld_d;
            tbl_src_q  <= tbl_src_d;
            cnt_q      <= cnt_d;
            rr_q       <= rr_d;
        end
    end

    assign bus.icache_data_ack_o = ack_i_s;
    assign bus.dcache_data_ack_o = ack_d_s;
    assign bus.mem_req_valid_o   = out_vld_q;
    assign bus.mem_req_o         = out_data_q;
    assign bus.mem_req_tid_o     = out_tid_q;
    assign bus.mem_req_src_o     = out_src_q;
    assign bus.icache_rtrn_vld_o = rtrn_i_s;
    assign bus.dcache_rtrn_vld_o = rtrn_d_s;
    assign bus.rtrn_data_o       = rtrn_data_s;
    assign bus.err_o             = err_s;
    assign bus.busy_o            = out_vld_q | (|tbl_vld_q);
endmodule
